// File: rtl/gate_pkg.sv
// gate_pkg: shared types and default constants for the parking-entrance
// barrier actuator.
//   gate_state_e : barrier FSM state encoding (3 bits)
//   DEF_*        : default parameter values for gate_actuator
package gate_pkg;

  typedef enum logic [2:0] {
    CLOSED  = 3'd0,
    OPENING = 3'd1,
    OPEN    = 3'd2,
    CLOSING = 3'd3,
    LOCKED  = 3'd4
  } gate_state_e;

  localparam int unsigned DEF_TRAVEL_CYCLES = 8;
  localparam int unsigned DEF_BLINK_HALF    = 4;
  localparam int unsigned DEF_CAPACITY      = 16;

endpackage

// File: rtl/occupancy_counter.sv
// occupancy_counter: saturating car-occupancy counter.
//   clock, reset : system clock, asynchronous active-high reset
//   C            : car-passed-barrier sensor (level, rising edge = car in)
//   salida       : car-exited sensor (level, rising edge = car out)
//   count_en     : entry edges only count while the barrier is up/closing
//   car_count    : cars currently inside, saturates at 0 and CAPACITY
//   full         : car_count == CAPACITY
module occupancy_counter #(
  parameter int unsigned CAPACITY = 16,
  parameter int unsigned CNT_W    = $clog2(CAPACITY + 1)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             C,
  input  logic             salida,
  input  logic             count_en,
  output logic [CNT_W-1:0] car_count,
  output logic             full
);

  localparam logic [CNT_W-1:0] CAP_V = CNT_W'(CAPACITY);

  logic c_d;
  logic salida_d;
  logic inc;
  logic dec;

  assign inc  = C && !c_d && count_en;
  assign dec  = salida && !salida_d;
  assign full = (car_count == CAP_V);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      c_d       <= 1'b0;
      salida_d  <= 1'b0;
      car_count <= '0;
    end else begin
      c_d      <= C;
      salida_d <= salida;
      // simultaneous entry and exit cancel out
      if (inc && !dec && !full) begin
        car_count <= car_count + 1'b1;
      end else if (dec && !inc && (car_count != '0)) begin
        car_count <= car_count - 1'b1;
      end
    end
  end

endmodule

// File: rtl/gate_actuator.sv
// gate_actuator: barrier motor driver downstream of the entrance controller.
//   clock, reset : system clock, asynchronous active-high reset
//   Aguja        : gate-open request (level)
//   Bloqueo      : lock/alarm request (level), highest priority
//   C, salida    : car-passed and car-exited sensors (level)
//   motor_up     : barrier travelling up
//   motor_down   : barrier travelling down
//   gate_open    : barrier fully raised
//   alarm_light  : blinking lamp while locked
//   car_count    : cars inside the lot
//   full         : lot at capacity, blocks new openings
module gate_actuator
  import gate_pkg::*;
#(
  parameter int unsigned TRAVEL_CYCLES = DEF_TRAVEL_CYCLES,
  parameter int unsigned BLINK_HALF    = DEF_BLINK_HALF,
  parameter int unsigned CAPACITY      = DEF_CAPACITY,
  parameter int unsigned CNT_W         = $clog2(CAPACITY + 1)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             Aguja,
  input  logic             Bloqueo,
  input  logic             C,
  input  logic             salida,
  output logic             motor_up,
  output logic             motor_down,
  output logic             gate_open,
  output logic             alarm_light,
  output logic [CNT_W-1:0] car_count,
  output logic             full
);

  localparam int unsigned PW = $clog2(TRAVEL_CYCLES + 1);
  localparam int unsigned BW = $clog2(BLINK_HALF + 1);

  localparam logic [PW-1:0] POS_MAX    = PW'(TRAVEL_CYCLES);
  localparam logic [PW-1:0] POS_NEAR   = PW'(TRAVEL_CYCLES - 1);
  localparam logic [PW-1:0] POS_ONE    = PW'(1);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_HALF - 1);

  gate_state_e   state;
  gate_state_e   state_n;
  logic [PW-1:0] pos;
  logic [PW-1:0] pos_n;
  logic [BW-1:0] blink_cnt;
  logic          lamp;
  logic          count_en;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= CLOSED;
      pos   <= '0;
    end else begin
      state <= state_n;
      pos   <= pos_n;
    end
  end

  // A reversal keeps pos for that cycle, so the opposite motor runs for
  // exactly the distance already travelled.
  always_comb begin
    state_n = state;
    pos_n   = pos;
    unique case (state)
      CLOSED: begin
        if (Bloqueo) begin
          state_n = LOCKED;
        end else if (Aguja && !full) begin
          state_n = OPENING;
        end
      end
      OPENING: begin
        if (Bloqueo) begin
          state_n = CLOSING;
        end else if (pos >= POS_NEAR) begin
          pos_n   = POS_MAX;
          state_n = OPEN;
        end else begin
          pos_n = pos + 1'b1;
        end
      end
      OPEN: begin
        if (Bloqueo || !Aguja) begin
          state_n = CLOSING;
        end
      end
      CLOSING: begin
        if (Aguja && !Bloqueo && !full) begin
          state_n = OPENING;
        end else if (pos <= POS_ONE) begin
          pos_n   = '0;
          state_n = Bloqueo ? LOCKED : CLOSED;
        end else begin
          pos_n = pos - 1'b1;
        end
      end
      LOCKED: begin
        pos_n = '0;
        if (!Bloqueo) begin
          state_n = CLOSED;
        end
      end
      default: begin
        state_n = CLOSED;
        pos_n   = '0;
      end
    endcase
  end

  // Lamp starts lit on entry to LOCKED and flips every BLINK_HALF cycles.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      lamp      <= 1'b0;
      blink_cnt <= '0;
    end else if ((state != LOCKED) && (state_n == LOCKED)) begin
      lamp      <= 1'b1;
      blink_cnt <= '0;
    end else if ((state == LOCKED) && (state_n == LOCKED)) begin
      if (blink_cnt == BLINK_LAST) begin
        blink_cnt <= '0;
        lamp      <= ~lamp;
      end else begin
        blink_cnt <= blink_cnt + 1'b1;
      end
    end else begin
      lamp      <= 1'b0;
      blink_cnt <= '0;
    end
  end

  assign motor_up    = (state == OPENING);
  assign motor_down  = (state == CLOSING);
  assign gate_open   = (state == OPEN);
  assign alarm_light = (state == LOCKED) && lamp;
  assign count_en    = (state == OPEN) || (state == CLOSING);

  occupancy_counter #(
    .CAPACITY (CAPACITY),
    .CNT_W    (CNT_W)
  ) u_occupancy (
    .clock     (clock),
    .reset     (reset),
    .C         (C),
    .salida    (salida),
    .count_en  (count_en),
    .car_count (car_count),
    .full      (full)
  );

endmodule

// File: doc/gate_actuator.md
# gate_actuator

Downstream stage of the parking-entrance controller. Consumes the controller's `Aguja` (gate-open request) and `Bloqueo` (lock/alarm) outputs plus the car-passed sensor `C`. Drives the barrier motor with a position counter, blinks the alarm lamp while locked, and keeps a saturating car-occupancy count that inhibits opening when the lot is full.

## Interface
Parameters:
- `TRAVEL_CYCLES`, 8: clock cycles for full barrier travel (≥2).
- `BLINK_HALF`, 4: cycles per alarm-lamp half period (≥1).
- `CAPACITY`, 16: lot capacity in cars (≥1).
- `CNT_W`, `$clog2(CAPACITY+1)`: width of `car_count`.

Ports:
- `clock` in 1: single system clock, rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `Aguja` in 1: gate-open request from controller, level.
- `Bloqueo` in 1: lock/alarm from controller, level.
- `C` in 1: car-passed-barrier sensor, level.
- `salida` in 1: car-exited sensor, level.
- `motor_up` out 1: drive barrier upward.
- `motor_down` out 1: drive barrier downward.
- `gate_open` out 1: barrier fully raised.
- `alarm_light` out 1: blinking lamp.
- `car_count` out CNT_W: cars currently inside.
- `full` out 1: `car_count == CAPACITY`.

## Operation
- Registered state: FSM state, `pos` (0..TRAVEL_CYCLES), blink counter, lamp bit, `car_count`, `c_d`/`salida_d` edge registers.
- States: CLOSED, OPENING, OPEN, CLOSING, LOCKED. Priority in every state: `Bloqueo` first, then other rules.
- CLOSED: `Bloqueo` → LOCKED. Otherwise `Aguja && !full` → OPENING.
- OPENING: `pos` increments every cycle. `Bloqueo` → CLOSING (reverse from current `pos`). When `pos` reaches TRAVEL_CYCLES → OPEN.
- OPEN: `Bloqueo` → CLOSING. `!Aguja` → CLOSING.
- CLOSING: `pos` decrements every cycle. `Aguja && !Bloqueo && !full` → OPENING (safety reopen from current `pos`). When `pos` reaches 0 → LOCKED if `Bloqueo`, else CLOSED.
- LOCKED: motor off. `!Bloqueo` → CLOSED. The barrier is guaranteed down (`pos == 0`) in this state.
- Moore outputs:
  - `motor_up` = OPENING.
  - `motor_down` = CLOSING.
  - `gate_open` = OPEN.
  - `alarm_light` = lamp bit in LOCKED, 0 elsewhere.
- Lamp:
  - Set to 1 on entry to LOCKED.
  - Toggles every BLINK_HALF cycles while in LOCKED.
  - Blink counter clears on exit.
- Occupancy:
  - A rising edge of `C` (`C && !c_d`) in OPEN or CLOSING is an increment. Edges in other states are ignored.
  - A rising edge of `salida` in any state is a decrement.
  - Increment and decrement in the same cycle: no change.
  - Saturates at CAPACITY and at 0.
  - `full` is combinational from `car_count`.
- `full` only blocks new openings. It does not abort an opening already in progress.

## Timing
- Reset (async assert, sync release) gives: state CLOSED, `pos` 0, `car_count` 0, all outputs 0, edge registers 0.
- Reset mid-travel returns to CLOSED with `pos` 0 immediately. Mechanical homing is out of scope.
- Inputs are sampled on the rising edge. An output reflects a state change right after that edge, so there is one cycle of latency from input to motor.
- `Aguja` high at edge k: `motor_up` high for exactly TRAVEL_CYCLES cycles from edge k. `gate_open` high from edge k+TRAVEL_CYCLES.
- `Aguja` low while OPEN: CLOSING after one edge. `motor_down` lasts TRAVEL_CYCLES cycles.
- Reversal at `pos = p`: the opposite motor runs for p cycles (closing) or TRAVEL_CYCLES−p cycles (opening). `motor_up` and `motor_down` are never both 1.
- A `C` edge raises `car_count` one cycle after the edge is sampled.

## Structure
- Package `gate_pkg`: state enum (CLOSED=0, OPENING, OPEN, CLOSING, LOCKED; 3 bits), default parameter constants.
- Sub-module `occupancy_counter`: edge detectors, saturating up/down counter, `full`. Parameters CAPACITY and CNT_W. Input `count_en` (OPEN|CLOSING) from the FSM.
- FSM, position counter and blinker live in the top module.

## Test plan
- Reset, `Aguja`=1 for 20 cycles, then 0 → `motor_up` 8 cycles, `gate_open` 1, then `motor_down` 8 cycles, back to CLOSED with `pos` 0.
- `Aguja`=1; at cycle 3 of OPENING assert `Bloqueo` → `motor_down` exactly 3 cycles, then LOCKED. `alarm_light` pattern 1111 0000 1111… until `Bloqueo`=0, then CLOSED with lamp 0.
- During CLOSING at `pos`=5, reassert `Aguja` → OPENING; `motor_up` 3 cycles, then OPEN.
- 16 `C` pulses while OPEN → `car_count`=16, `full`=1. The 17th pulse keeps 16. A new `Aguja` from CLOSED does not open. One `salida` pulse → 15, `full`=0, and `Aguja` opens.
- `C` and `salida` rising edges in the same cycle at count 7 → stays 7. `C` pulse while CLOSED → no change. `salida` at count 0 → stays 0.
- Assert `reset` mid-OPENING with count 5 → all outputs 0, count 0 immediately, without waiting for a clock edge.
